// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one combinational ALU between two requesters,
// with a private carry flag per requester and a registered, tagged response.
module alu_arbiter #(
    parameter logic FIRST_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [7:0]  alu_op,
    output logic        alu_carry_in,
    input  logic [31:0] alu_c,
    input  logic        alu_carry_out,
    input  logic        alu_zero,
    input  logic        alu_neg,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_c,
    output logic        rsp_carry,
    output logic        rsp_zero,
    output logic        rsp_neg,
    output logic        rsp_illegal
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic        winner, accept, exec, illegal;
    logic        last_grant_q, id_q;
    logic [1:0]  carry_q;
    logic [7:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] rsp_c_q;
    logic        rsp_id_q, rsp_carry_q, rsp_zero_q, rsp_neg_q, rsp_illegal_q;

    // Sole requester wins; on a tie the one not granted last time wins.
    always_comb begin
        unique case (req_valid)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant_q;
            default: winner = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|req_valid) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept    = 1'b0;
        exec      = 1'b0;
        rsp_valid = 1'b0;
        req_ready = 2'b00;
        unique case (state_q)
            IDLE: begin
                accept    = |req_valid;
                req_ready = req_valid & {winner, ~winner};
            end
            EXEC:    exec = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        illegal = !((op_q <= 8'd8) || (op_q == 8'd12) || (op_q == 8'd13));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q  <= ~FIRST_PRIO;
            id_q          <= 1'b0;
            op_q          <= 8'd0;
            a_q           <= 32'd0;
            b_q           <= 32'd0;
            carry_q       <= 2'b00;
            rsp_id_q      <= 1'b0;
            rsp_c_q       <= 32'd0;
            rsp_carry_q   <= 1'b0;
            rsp_zero_q    <= 1'b0;
            rsp_neg_q     <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q         <= winner ? req_op[15:8]  : req_op[7:0];
                a_q          <= winner ? req_a[63:32]  : req_a[31:0];
                b_q          <= winner ? req_b[63:32]  : req_b[31:0];
                id_q         <= winner;
                last_grant_q <= winner;
            end
            if (exec) begin
                rsp_c_q       <= alu_c;
                rsp_carry_q   <= alu_carry_out;
                rsp_zero_q    <= alu_zero;
                rsp_neg_q     <= alu_neg;
                rsp_id_q      <= id_q;
                rsp_illegal_q <= illegal;
                carry_q[id_q] <= alu_carry_out;
            end
        end
    end

    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_op       = op_q;
    assign alu_carry_in = carry_q[id_q];

    assign rsp_id      = rsp_id_q;
    assign rsp_c       = rsp_c_q;
    assign rsp_carry   = rsp_carry_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_neg     = rsp_neg_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule
